serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial ripple-borrow subtractor: computes a − b − bin one bit per clock, LSB first.
- Returns the difference, the per-bit borrow vector and a start/busy/done handshake.
- Inverse companion to the team's ripple-carry adder: it recovers an operand from a sum. It lives in the arithmetic-circuits set for multi-cycle datapaths where one full-subtractor cell is shared across bits.

Parameters:
- WIDTH, 3, operand/result width in bits (≥1).

Ports:
- clk  input  1  rising-edge clock.
- areset  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse: diff/bout newly valid.
- diff  output  WIDTH  result (a − b − bin) mod 2^WIDTH.
- bout  output  WIDTH  bout[i] = borrow out of bit i; bout[WIDTH-1] is the final borrow.

Behaviour:
- Clock and reset
  - One clock domain.
  - areset asserted → immediately: state=IDLE; busy=0, done=0, diff=0, bout=0; internal operand/borrow/bit-counter regs=0.
  - Reset mid-operation aborts the operation; no done is produced.
- States
  - IDLE: busy=0. start=1 at an edge → capture a, b, bin; counter=0; go RUN.
  - RUN: busy=1. Each edge processes bit i=counter:
    - d = a[i]^b[i]^br
    - br' = (~a[i]&b[i]) | (~(a[i]^b[i])&br)
    - br starts at the captured bin.
    - d and br' are written into internal diff/bout shift registers at position i; counter increments.
    - On the edge that processes i=WIDTH-1: load diff/bout outputs from the shift registers; done=1; go DONE.
  - DONE: busy=0, done=1 for exactly this cycle.
    - start=1 at the next edge → accepted as in IDLE (back-to-back), going to RUN.
    - Otherwise go IDLE.
- Latency
  - start sampled at edge k → busy=1 from k to k+WIDTH.
  - done=1 and results valid after edge k+WIDTH.
  - Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- Output holding
  - diff/bout update only at completion.
  - They hold their value through subsequent IDLE/RUN until the next completion; they are never partially updated.
- Input handling
  - start while busy=1 is ignored; not queued.
  - a/b/bin changes after capture do not affect the current operation.
- Widths and counter
  - All arithmetic is modulo 2^WIDTH.
  - The counter width is sufficient for WIDTH; it wraps to 0 only via a new start.
  - WIDTH=1 → RUN lasts one cycle.

Test Plan:
- Reset/idle: assert areset mid-RUN (WIDTH=3, a=5, b=3) → busy, done, diff and bout go 0 immediately; no done pulse after release; next start works normally.
- No-borrow case: a=5, b=3, bin=0, start for one cycle → busy high 3 cycles; done pulse 3 edges after start; diff=3'b010, bout=3'b010, final borrow 0.
- Underflow: a=2, b=5, bin=0 → diff=3'b101 (−3 mod 8), bout=3'b101, final borrow 1.
- Borrow-in propagation: a=0, b=0, bin=1 → diff=3'b111, bout=3'b111.
- Handshake: pulse start again during busy with a=7, b=1 → ignored; the original result is produced.
  - Then hold start high during the done cycle with a=7, b=1, bin=0 → accepted back-to-back.
  - Result after 3 more edges: diff=3'b110, bout=3'b000.
- Round-trip against adder: randomized a, b, cin with WIDTH=8. Feed the adder's sum as minuend, b as subtrahend, cin as bin → diff==a, bout[7]==0 whenever the adder's final carry is 0. Run ≥1000 vectors.

Source files
------------

// File: rtl/serial_subtractor_if.sv
//------------------------------------------------------------------------------
// serial_subtractor_if : request/result bundle for the bit-serial subtractor.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface serial_subtractor_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// serial_subtractor : bit-serial ripple-borrow subtractor, a - b - bin, LSB first.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 3
) (
    input  wire logic          clk,
    input  wire logic          areset,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dsh;
    logic [WIDTH-1:0] r_bsh;
    logic [WIDTH-1:0] r_diff;
    logic [WIDTH-1:0] r_bout;
    logic             r_busy;
    logic             r_done;

    logic             w_ai;
    logic             w_bi;
    logic             w_d;
    logic             w_br_nxt;
    logic [WIDTH-1:0] w_dsh_nxt;
    logic [WIDTH-1:0] w_bsh_nxt;

    // Single shared full-subtractor cell, steered by the bit counter.
    always_comb begin
        w_ai      = r_a[r_cnt];
        w_bi      = r_b[r_cnt];
        w_d       = w_ai ^ w_bi ^ r_br;
        w_br_nxt  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
        w_dsh_nxt = r_dsh;
        w_bsh_nxt = r_bsh;
        w_dsh_nxt[r_cnt] = w_d;
        w_bsh_nxt[r_cnt] = w_br_nxt;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_dsh   <= '0;
            r_bsh   <= '0;
            r_diff  <= '0;
            r_bout  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_dsh <= w_dsh_nxt;
                    r_bsh <= w_bsh_nxt;
                    r_br  <= w_br_nxt;
                    if (r_cnt == C_LAST) begin
                        // Results leave the shift registers in one step so the
                        // visible outputs never show a partial word.
                        r_diff  <= w_dsh_nxt;
                        r_bout  <= w_bsh_nxt;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_br    <= bus.bin;
                        r_cnt   <= '0;
                        r_dsh   <= '0;
                        r_bsh   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//------------------------------------------------------------------------------
// tb_serial_subtractor : directed and adder round-trip bench for serial_subtractor.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

    logic clk = 1'b0;
    logic areset;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(3)) if3 ();
    serial_subtractor_if #(.WIDTH(8)) if8 ();

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk    (clk),
        .areset (areset),
        .bus    (if3.slave)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .areset (areset),
        .bus    (if8.slave)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] bo;
    } exp_t;

    exp_t q3[$];
    exp_t q8[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Borrow out of bit i: the low i+1 bits of a cannot cover those of b plus bin.
    function automatic logic [7:0] ref_bout(input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            int m;
            m = 1 << (i + 1);
            r[i] = ((int'(a) % m) < ((int'(b) % m) + int'(bi)));
        end
        return r;
    endfunction

    task automatic drive3(input logic [2:0] a, input logic [2:0] b, input logic bi,
                          input bit push, input logic [2:0] ed, input logic [2:0] eb);
        exp_t e;
        if3.start = 1'b1;
        if3.a     = a;
        if3.b     = b;
        if3.bin   = bi;
        if (push) begin
            e.d  = 8'(ed);
            e.bo = 8'(eb);
            q3.push_back(e);
        end
    endtask

    task automatic wait_done3(input string tag, input int exp_n);
        int   n;
        exp_t e;
        n = 0;
        while (if3.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, exp_n);
        if (if3.done === 1'b1) begin
            check({tag, "_sb_nonempty"}, (q3.size() > 0), 1);
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check({tag, "_diff"}, 32'(if3.diff), 32'(e.d));
                check({tag, "_bout"}, 32'(if3.bout), 32'(e.bo));
                check({tag, "_busy_at_done"}, 32'(if3.busy), 0);
            end
        end
    endtask

    task automatic single3(input string tag, input logic [2:0] a, input logic [2:0] b,
                           input logic bi, input logic [2:0] ed, input logic [2:0] eb);
        @(negedge clk);
        drive3(a, b, bi, 1'b1, ed, eb);
        @(negedge clk);
        if3.start = 1'b0;
        check({tag, "_busy"}, 32'(if3.busy), 1);
        check({tag, "_done_low"}, 32'(if3.done), 0);
        wait_done3(tag, 3);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(if3.done), 0);
        check({tag, "_hold"}, 32'(if3.diff), 32'(ed));
    endtask

    task automatic trip8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [8:0] s;
        exp_t       e;
        int         n;
        s        = 9'(a) + 9'(b) + 9'(cin);
        e.d      = a;
        e.bo     = ref_bout(s[7:0], b, cin);
        q8.push_back(e);
        @(negedge clk);
        if8.start = 1'b1;
        if8.a     = s[7:0];
        if8.b     = b;
        if8.bin   = cin;
        @(negedge clk);
        if8.start = 1'b0;
        n = 0;
        while (if8.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rt_latency", n, 8);
        if (if8.done === 1'b1 && q8.size() > 0) begin
            e = q8.pop_front();
            check("rt_diff", 32'(if8.diff), 32'(e.d));
            check("rt_bout", 32'(if8.bout), 32'(e.bo));
            check("rt_final_borrow", 32'(if8.bout[7]), 32'(s[8]));
        end
    endtask

    initial begin
        int seen;

        areset    = 1'b1;
        if3.start = 1'b0; if3.a = '0; if3.b = '0; if3.bin = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(if3.busy), 0);
        check("rst_done", 32'(if3.done), 0);
        check("rst_diff", 32'(if3.diff), 0);
        check("rst_bout", 32'(if3.bout), 0);
        areset = 1'b0;

        single3("noborrow",  3'd5, 3'd3, 1'b0, 3'b010, 3'b010);
        single3("underflow", 3'd2, 3'd5, 1'b0, 3'b101, 3'b101);
        single3("borrowin",  3'd0, 3'd0, 1'b1, 3'b111, 3'b111);

        // Start held through RUN with new operands: ignored, original result stands.
        @(negedge clk);
        drive3(3'd5, 3'd3, 1'b0, 1'b1, 3'b010, 3'b010);
        @(negedge clk);
        check("ign_busy", 32'(if3.busy), 1);
        drive3(3'd7, 3'd1, 1'b0, 1'b0, 3'b000, 3'b000);
        @(negedge clk);
        if3.start = 1'b0;
        check("ign_hold_diff", 32'(if3.diff), 32'(3'b111));
        wait_done3("ign", 2);

        // Back-to-back: start presented during the done cycle.
        drive3(3'd7, 3'd1, 1'b0, 1'b1, 3'b110, 3'b000);
        @(negedge clk);
        if3.start = 1'b0;
        check("b2b_busy", 32'(if3.busy), 1);
        check("b2b_done_low", 32'(if3.done), 0);
        wait_done3("b2b", 3);

        // Reset in the middle of RUN.
        @(negedge clk);
        drive3(3'd5, 3'd3, 1'b0, 1'b0, 3'b000, 3'b000);
        @(negedge clk);
        if3.start = 1'b0;
        @(negedge clk);
        areset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(if3.busy), 0);
        check("mid_rst_done", 32'(if3.done), 0);
        check("mid_rst_diff", 32'(if3.diff), 0);
        check("mid_rst_bout", 32'(if3.bout), 0);
        @(negedge clk);
        areset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (if3.done === 1'b1 || if3.busy === 1'b1) seen++;
        end
        check("mid_rst_no_done", seen, 0);
        single3("after_rst", 3'd5, 3'd3, 1'b0, 3'b010, 3'b010);

        for (int i = 0; i < 1000; i++) begin
            trip8(8'($urandom), 8'($urandom), 1'($urandom));
        end
        trip8(8'hFF, 8'hFF, 1'b1);
        trip8(8'h00, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
